// File: rtl/smm_stream_bridge.sv
// Streaming bridge for the 4x4 Strassen multiply core. It packs 16 A elements and
// then 16 B elements into wide operand buses, fires one load pulse, captures the
// result LATENCY cycles later and drains the 16 result elements row-major.
// Latency: the result is captured at the end of cycle t+LATENCY after mm_load in
// cycle t, and m_valid_o rises in cycle t+LATENCY+1.
// Backpressure: s_ready_o is low outside FILL_A/FILL_B, and the drain holds its
// element until m_ready_i is high.
// Ports: clk_i/rst_ni (async active-low); s_data_i/s_valid_i/s_ready_o/cfg_sel_i
// form the operand stream; mm_a_o/mm_b_o/mm_load_o/mm_sel_o/mm_c_i connect to the
// core; m_data_o/m_valid_o/m_ready_i/m_last_o form the result stream; perf_jobs_o
// is present only when SMM_BRIDGE_PERF_EN is defined.
module smm_stream_bridge #(
   parameter int DATAWIDTH = 32,
   parameter int BUSWIDTH  = DATAWIDTH*16,
   parameter int LATENCY   = 6
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [DATAWIDTH-1:0] s_data_i,
   input  logic                 s_valid_i,
   output logic                 s_ready_o,
   input  logic                 cfg_sel_i,
   output logic [BUSWIDTH-1:0]  mm_a_o,
   output logic [BUSWIDTH-1:0]  mm_b_o,
   output logic                 mm_load_o,
   output logic                 mm_sel_o,
   input  logic [BUSWIDTH-1:0]  mm_c_i,
   output logic [DATAWIDTH-1:0] m_data_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
`ifdef SMM_BRIDGE_PERF_EN
   output logic [31:0]          perf_jobs_o,
`endif
   output logic                 m_last_o
);

   localparam int CW = $clog2(LATENCY+1);

   typedef enum logic [2:0] {FILL_A, FILL_B, ISSUE, WAIT, DRAIN} state_e;

   state_e               state_q, state_d;
   logic [3:0]           idx_q, idx_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BUSWIDTH-1:0]  mm_a_q, mm_a_d;
   logic [BUSWIDTH-1:0]  mm_b_q, mm_b_d;
   logic [BUSWIDTH-1:0]  res_q, res_d;
   logic                 sel_q, sel_d;
   logic                 s_hs, m_hs;

   // s_ready is gated by reset so nothing is accepted while reset is asserted.
   assign s_ready_o = rst_ni && ((state_q == FILL_A) || (state_q == FILL_B));
   assign mm_load_o = (state_q == ISSUE);
   assign m_valid_o = (state_q == DRAIN);
   assign m_last_o  = (state_q == DRAIN) && (idx_q == 4'd15);
   assign m_data_o  = res_q[idx_q*DATAWIDTH +: DATAWIDTH];
   assign mm_a_o    = mm_a_q;
   assign mm_b_o    = mm_b_q;
   assign mm_sel_o  = sel_q;

   assign s_hs = s_valid_i && s_ready_o;
   assign m_hs = m_valid_o && m_ready_i;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      mm_a_d  = mm_a_q;
      mm_b_d  = mm_b_q;
      res_d   = res_q;
      sel_d   = sel_q;
      case (state_q)
         FILL_A: begin
            if (s_hs) begin
               mm_a_d[idx_q*DATAWIDTH +: DATAWIDTH] = s_data_i;
               // Mode is taken from the first A element only.
               if (idx_q == 4'd0) sel_d = cfg_sel_i;
               if (idx_q == 4'd15) begin
                  idx_d   = 4'd0;
                  state_d = FILL_B;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         FILL_B: begin
            if (s_hs) begin
               mm_b_d[idx_q*DATAWIDTH +: DATAWIDTH] = s_data_i;
               if (idx_q == 4'd15) begin
                  idx_d   = 4'd0;
                  state_d = ISSUE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         ISSUE: begin
            // The counter reaches 0 exactly LATENCY cycles after the load cycle.
            cnt_d   = CW'(LATENCY-1);
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == '0) begin
               res_d   = mm_c_i;
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DRAIN: begin
            if (m_hs) begin
               if (idx_q == 4'd15) begin
                  idx_d   = 4'd0;
                  state_d = FILL_A;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = FILL_A;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= FILL_A;
         idx_q   <= 4'd0;
         cnt_q   <= '0;
         mm_a_q  <= '0;
         mm_b_q  <= '0;
         res_q   <= '0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         mm_a_q  <= mm_a_d;
         mm_b_q  <= mm_b_d;
         res_q   <= res_d;
         sel_q   <= sel_d;
      end
   end

`ifdef SMM_BRIDGE_PERF_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (m_hs && m_last_o) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) perf_q <= 32'd0;
      else         perf_q <= perf_d;
   end

   assign perf_jobs_o = perf_q;
`endif

endmodule
